// File: rtl/slip_mem_sequencer.sv
// slip_mem_sequencer
//   Shares one DRAM between three bus masters (0=CPU, 1=blitter, 2=DSP).
//   Grants one access at a time in round-robin order. Generates registered
//   RAS/CAS strobes and the row/column address-mux select. Inserts a
//   CAS-before-RAS refresh every REFRESH_PERIOD cycles. This block is control
//   only; the address and data muxing that row_sel steers lives elsewhere.
//
// Ports
//   MasterClock      in   1  system clock, rising edge
//   rL               in   1  asynchronous active-low reset
//   req              in   3  per-master request level, held until that master's done
//   gnt              out  3  one-hot owner of the current access, 0 when idle/refreshing
//   done             out  3  one-cycle pulse to the owner in the final CAS cycle
//   ras_l            out  1  DRAM row strobe, active low
//   cas_l            out  1  DRAM column strobe, active low
//   row_sel          out  1  1 = row address, 0 = column address
//   refresh_pending  out  1  refresh due and not yet started
//   refresh_overrun  out  1  sticky: timer expired while a refresh was still pending
//
// Every output is a flop, so req has no combinational path to any pin.

module slip_mem_sequencer #(
  parameter int unsigned RAS_CYCLES     = 2,
  parameter int unsigned CAS_CYCLES     = 2,
  parameter int unsigned REFRESH_PERIOD = 64
) (
  input  logic       MasterClock,
  input  logic       rL,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic       ras_l,
  output logic       cas_l,
  output logic       row_sel,
  output logic       refresh_pending,
  output logic       refresh_overrun
);

  // The phase counter must hold the longest phase: refresh RAS+CAS.
  localparam int unsigned PW = (RAS_CYCLES + CAS_CYCLES > 1) ? $clog2(RAS_CYCLES + CAS_CYCLES) : 1;
  localparam int unsigned TW = $clog2(REFRESH_PERIOD);

  localparam logic [PW-1:0] P_ONE    = PW'(1);
  localparam logic [PW-1:0] P_RAS_LD = PW'(RAS_CYCLES - 1);
  localparam logic [PW-1:0] P_CAS_LD = PW'(CAS_CYCLES - 1);
  localparam logic [PW-1:0] P_REF_LD = PW'(RAS_CYCLES + CAS_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [TW-1:0] T_LD     = TW'(REFRESH_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAS,
    S_CAS,
    S_PRE,
    S_RCAS,
    S_RRAS
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_cnt;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_rr;
  logic          w_expire;
  logic [1:0]    w_win_idx;
  logic [2:0]    w_win_oh;

  // The refresh timer runs freely in every state.
  assign w_expire = (r_timer == '0);

  always_ff @(posedge MasterClock or negedge rL) begin
    if (!rL) begin
      r_timer <= T_LD;
    end else if (w_expire) begin
      r_timer <= T_LD;
    end else begin
      r_timer <= r_timer - T_ONE;
    end
  end

  // Round-robin search. It starts at the master after the last winner.
  // If nothing else requests, the search falls back to r_rr itself. That
  // result is only used when |req, so the fallback only matters when
  // req[r_rr] is the sole requester.
  always_comb begin
    w_win_idx = 2'd0;
    case (r_rr)
      2'd0:    w_win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    w_win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: w_win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    w_win_oh = 3'b001 << w_win_idx;
  end

  always_ff @(posedge MasterClock or negedge rL) begin
    if (!rL) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_rr            <= 2'd2;
      gnt             <= '0;
      done            <= '0;
      ras_l           <= 1'b1;
      cas_l           <= 1'b1;
      row_sel         <= 1'b1;
      refresh_pending <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      done <= '0;

      if (w_expire && refresh_pending) begin
        refresh_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (refresh_pending) begin
            r_state         <= S_RCAS;
            cas_l           <= 1'b0;
            row_sel         <= 1'b0;
            refresh_pending <= 1'b0;
          end else if (|req) begin
            r_state <= S_RAS;
            gnt     <= w_win_oh;
            r_rr    <= w_win_idx;
            ras_l   <= 1'b0;
            r_cnt   <= P_RAS_LD;
          end
        end

        S_RAS: begin
          if (r_cnt == '0) begin
            r_state <= S_CAS;
            cas_l   <= 1'b0;
            row_sel <= 1'b0;
            r_cnt   <= P_CAS_LD;
            // A single-cycle column phase is also the final CAS cycle.
            if (CAS_CYCLES == 1) begin
              done <= gnt;
            end
          end else begin
            r_cnt <= r_cnt - P_ONE;
          end
        end

        S_CAS: begin
          if (r_cnt == '0) begin
            r_state <= S_PRE;
            gnt     <= '0;
            ras_l   <= 1'b1;
            cas_l   <= 1'b1;
            row_sel <= 1'b1;
          end else begin
            r_cnt <= r_cnt - P_ONE;
            // done is registered, so it is loaded one cycle ahead of the
            // last column cycle.
            if (r_cnt == P_ONE) begin
              done <= gnt;
            end
          end
        end

        S_PRE: begin
          r_state <= S_IDLE;
        end

        S_RCAS: begin
          r_state <= S_RRAS;
          ras_l   <= 1'b0;
          r_cnt   <= P_REF_LD;
        end

        S_RRAS: begin
          if (r_cnt == '0) begin
            r_state <= S_PRE;
            ras_l   <= 1'b1;
            cas_l   <= 1'b1;
            row_sel <= 1'b1;
          end else begin
            r_cnt <= r_cnt - P_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          gnt     <= '0;
          ras_l   <= 1'b1;
          cas_l   <= 1'b1;
          row_sel <= 1'b1;
        end
      endcase

      // Placed last so that a timer expiry on the same edge as RCAS entry
      // keeps pending set.
      if (w_expire) begin
        refresh_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slip_mem_sequencer.sv
module tb_slip_mem_sequencer;

  logic       clk;
  logic       rL;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [2:0] done;
  logic       ras_l;
  logic       cas_l;
  logic       row_sel;
  logic       pend;
  logic       ovr;

  logic       rL2;
  logic [2:0] req2;
  logic [2:0] gnt2;
  logic [2:0] done2;
  logic       ras2;
  logic       cas2;
  logic       rs2;
  logic       pend2;
  logic       ovr2;

  int checks = 0;
  int errors = 0;
  int cyc  = 0;
  int cyc2 = 0;

  typedef struct {
    int         cyc;
    logic [2:0] val;
  } ev_t;

  ev_t exp_gnt[$];
  ev_t exp_done[$];
  int  exp_rcas[$];

  logic [2:0] prev_gnt = '0;

  slip_mem_sequencer #(
    .RAS_CYCLES    (2),
    .CAS_CYCLES    (2),
    .REFRESH_PERIOD(64)
  ) u_dut (
    .MasterClock    (clk),
    .rL             (rL),
    .req            (req),
    .gnt            (gnt),
    .done           (done),
    .ras_l          (ras_l),
    .cas_l          (cas_l),
    .row_sel        (row_sel),
    .refresh_pending(pend),
    .refresh_overrun(ovr)
  );

  // This instance has long phases, so refresh runs back to back and overruns.
  slip_mem_sequencer #(
    .RAS_CYCLES    (4),
    .CAS_CYCLES    (4),
    .REFRESH_PERIOD(8)
  ) u_dut_ovr (
    .MasterClock    (clk),
    .rL             (rL2),
    .req            (req2),
    .gnt            (gnt2),
    .done           (done2),
    .ras_l          (ras2),
    .cas_l          (cas2),
    .row_sel        (rs2),
    .refresh_pending(pend2),
    .refresh_overrun(ovr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle k is the interval after the k-th rising edge that follows reset release.
  always @(posedge clk or negedge rL) begin
    if (!rL) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(posedge clk or negedge rL2) begin
    if (!rL2) cyc2 <= 0;
    else      cyc2 <= cyc2 + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_cyc2(input int k);
    while (cyc2 < k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_gnt(input int c, input logic [2:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_gnt.push_back(e);
  endtask

  task automatic push_done(input int c, input logic [2:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_done.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},     32'(gnt),     32'd0);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_strobes"}, 32'({ras_l, cas_l, row_sel}), 32'b111);
    chk({tag, "_pend"},    32'(pend),    32'd0);
    chk({tag, "_ovr"},     32'(ovr),     32'd0);
  endtask

  // The monitor pops an expected event whenever the main DUT starts a grant,
  // pulses done or enters RCAS (cas_l low while ras_l is still high).
  always @(negedge clk) begin
    if (rL) begin
      if (gnt != 3'b000 && prev_gnt == 3'b000) begin
        if (exp_gnt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got %b at cycle %0d, expected none", gnt, cyc);
        end else begin
          ev_t e;
          e = exp_gnt.pop_front();
          chk("grant_cycle", 32'(cyc), 32'(e.cyc));
          chk("grant_value", 32'(gnt), 32'(e.val));
        end
      end
      if (done != 3'b000) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got %b at cycle %0d, expected none", done, cyc);
        end else begin
          ev_t e;
          e = exp_done.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_value", 32'(done), 32'(e.val));
        end
      end
      if (ras_l && !cas_l) begin
        if (exp_rcas.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rcas: got rcas at cycle %0d, expected none", cyc);
        end else begin
          int c;
          c = exp_rcas.pop_front();
          chk("rcas_cycle", 32'(cyc), 32'(c));
          chk("rcas_gnt", 32'(gnt), 32'd0);
        end
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rL   = 1'b0;
    rL2  = 1'b0;
    req  = 3'b000;
    req2 = 3'b000;
    #23;

    // Single master, full access timing.
    @(negedge clk);
    req = 3'b001;
    #2 rL = 1'b1;
    chk_reset_vals("reset");
    push_gnt(1, 3'b001);  push_done(4, 3'b001);
    push_gnt(7, 3'b001);  push_done(10, 3'b001);
    wait_cyc(2);
    chk("ras_phase", 32'({ras_l, cas_l, row_sel}), 32'b011);
    wait_cyc(3);
    chk("cas_phase", 32'({ras_l, cas_l, row_sel}), 32'b000);
    wait_cyc(5);
    chk("pre_phase", 32'({gnt, ras_l, cas_l, row_sel}), 32'b000_111);
    wait_cyc(6);
    chk("idle_gap_gnt", 32'(gnt), 32'd0);

    // All masters requesting: rotation 010,100,001,010 after master 0's turn.
    wait_cyc(10);
    req = 3'b111;
    push_gnt(13, 3'b010); push_done(16, 3'b010);
    push_gnt(19, 3'b100); push_done(22, 3'b100);
    push_gnt(25, 3'b001); push_done(28, 3'b001);
    push_gnt(31, 3'b010); push_done(34, 3'b010);
    wait_cyc(34);
    req = 3'b000;

    // Request dropped in the RAS phase still completes with done.
    wait_cyc(40);
    req = 3'b010;
    push_gnt(41, 3'b010); push_done(44, 3'b010);
    wait_cyc(41);
    req = 3'b000;
    wait_cyc(48);
    chk("idle_hold", 32'({gnt, ras_l}), 32'b000_1);

    // Refresh falls due in the middle of an access and waits for PRE->IDLE.
    wait_cyc(61);
    req = 3'b001;
    push_gnt(62, 3'b001); push_done(65, 3'b001);
    exp_rcas.push_back(68);
    wait_cyc(63);
    chk("pend_before_expiry", 32'(pend), 32'd0);
    wait_cyc(64);
    chk("pend_at_expiry", 32'(pend), 32'd1);
    wait_cyc(65);
    req = 3'b000;
    wait_cyc(67);
    chk("pend_waits_idle", 32'(pend), 32'd1);
    wait_cyc(68);
    chk("pend_cleared_rcas", 32'(pend), 32'd0);
    wait_cyc(70);
    chk("rras_strobes", 32'({gnt, ras_l, cas_l}), 32'b000_00);

    // Asynchronous reset during CAS aborts the access with no done pulse.
    wait_cyc(75);
    req = 3'b111;
    push_gnt(76, 3'b010);
    wait_cyc(78);
    chk("abort_in_cas", 32'({gnt, cas_l}), 32'b010_0);
    rL = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    req = 3'b000;
    chk("queues_drained_a", 32'(exp_gnt.size() + exp_done.size() + exp_rcas.size()), 32'd0);

    // Idle after reset: refresh comes first as RCAS, then RRAS.
    @(negedge clk);
    #2 rL = 1'b1;
    wait_cyc(63);
    chk("idle_pend_63", 32'(pend), 32'd0);
    wait_cyc(64);
    chk("idle_pend_64", 32'(pend), 32'd1);
    exp_rcas.push_back(65);
    wait_cyc(65);
    chk("rcas_shape", 32'({pend, ras_l, cas_l, row_sel}), 32'b0100);
    wait_cyc(66);
    chk("rras_shape", 32'({gnt, ras_l, cas_l}), 32'b000_00);
    wait_cyc(70);
    chk("refresh_pre", 32'({ras_l, cas_l, ovr}), 32'b110);
    chk("queues_drained_b", 32'(exp_gnt.size() + exp_done.size() + exp_rcas.size()), 32'd0);

    // Overrun: long accesses with a short refresh period and all masters requesting.
    rL = 1'b0;
    @(negedge clk);
    req2 = 3'b111;
    #2 rL2 = 1'b1;
    wait_cyc2(1);
    chk("ovr_first_grant", 32'(gnt2), 32'b001);
    wait_cyc2(8);
    chk("ovr_pend_8", 32'(pend2), 32'd1);
    wait_cyc2(11);
    chk("ovr_refresh_beats_req", 32'({gnt2, ras2, cas2}), 32'b000_10);
    wait_cyc2(31);
    chk("ovr_before", 32'(ovr2), 32'd0);
    wait_cyc2(32);
    chk("ovr_set", 32'(ovr2), 32'd1);
    wait_cyc2(60);
    chk("ovr_sticky", 32'(ovr2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
